// File: rtl/ahb_slave_arbiter_gen_if.sv
// ----------------------------------------------------------------------------
// ahb_slave_arbiter_gen_if
// Bundles the request side and grant side of one per-slave arbiter.
//   hreq     : per-master request, level-held
//   hburst   : per-master burst type (SINGLE=0 .. INCR16=7)
//   hprior   : per-master dynamic priority, larger wins
//   arb_mode : 0 fixed, 1 round-robin, 2 dynamic, 3 fixed
//   hwait    : slave stall
//   hgrant   : registered one-hot grant
//   hsel     : any grant active
//   hmaster  : index of the granted master (0 when idle)
//   hlast    : pulse on the final accepted beat of an ownership
// Modport "master" is the requester/slave side that drives requests,
// modport "slave" is the arbiter itself.
// ----------------------------------------------------------------------------
interface ahb_slave_arbiter_gen_if #(
   parameter int MASTER_NUM = 4,
   parameter int PRIOR_BIT  = 2,
   parameter int IDX_W      = $clog2(MASTER_NUM)
);
   logic [MASTER_NUM-1:0]                hreq;
   logic [MASTER_NUM-1:0][2:0]           hburst;
   logic [MASTER_NUM-1:0][PRIOR_BIT-1:0] hprior;
   logic [1:0]                           arb_mode;
   logic                                 hwait;
   logic [MASTER_NUM-1:0]                hgrant;
   logic                                 hsel;
   logic [IDX_W-1:0]                     hmaster;
   logic                                 hlast;

   modport master (
      output hreq, hburst, hprior, arb_mode, hwait,
      input  hgrant, hsel, hmaster, hlast
   );

   modport slave (
      input  hreq, hburst, hprior, arb_mode, hwait,
      output hgrant, hsel, hmaster, hlast
   );
endinterface

// File: rtl/ahb_slave_arbiter_gen.sv
// ----------------------------------------------------------------------------
// ahb_slave_arbiter_gen
// Per-slave AHB arbiter. Picks one requesting master (fixed, round-robin or
// dynamic priority, chosen at run time) and holds the grant for the whole
// burst. Fixed-length bursts end after their beat count; INCR bursts end when
// the owner drops its request or after HOLD_MAX accepted beats.
// Ports:
//   hclk    : clock, rising edge
//   hreset  : asynchronous active-high reset
//   arb_if  : slave modport of ahb_slave_arbiter_gen_if (requests in,
//             hgrant/hsel/hmaster/hlast out)
// ----------------------------------------------------------------------------
module ahb_slave_arbiter_gen #(
   parameter int MASTER_NUM = 4,
   parameter int PRIOR_BIT  = 2,
   parameter int HOLD_MAX   = 16,
   parameter int IDX_W      = $clog2(MASTER_NUM)
) (
   input  logic                   hclk,
   input  logic                   hreset,
   ahb_slave_arbiter_gen_if.slave arb_if
);
   // Beat counter wide enough for HOLD_MAX, never narrower than 5 bits.
   localparam int CNT_W = ($clog2(HOLD_MAX + 1) > 5) ? $clog2(HOLD_MAX + 1) : 5;

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [MASTER_NUM-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]      beat_limit_q, beat_limit_d;
   logic [2:0]            burst_q, burst_d;

   logic                  win_found;
   logic [IDX_W-1:0]      win_idx;
   logic [PRIOR_BIT-1:0]  best_prio;
   logic                  acc_c;
   logic                  owner_req_c;
   logic                  rel_c;
   logic [IDX_W-1:0]      master_c;
   logic [MASTER_NUM-1:0][IDX_W-1:0] idx_terms;

   function automatic logic [CNT_W-1:0] limit_of(input logic [2:0] b);
      case (b)
         3'd0:        limit_of = CNT_W'(1);
         3'd1:        limit_of = CNT_W'(HOLD_MAX);
         3'd2, 3'd3:  limit_of = CNT_W'(4);
         3'd4, 3'd5:  limit_of = CNT_W'(8);
         default:     limit_of = CNT_W'(16);
      endcase
   endfunction

   // hmaster is an OR of the indices of set grant bits; hgrant is one-hot
   // and registered, so the decode follows it cleanly.
   genvar gi;
   generate
      for (gi = 0; gi < MASTER_NUM; gi++) begin : g_idx
         assign idx_terms[gi] = grant_q[gi] ? IDX_W'(gi) : '0;
      end
   endgenerate

   always_comb begin
      master_c = '0;
      for (int i = 0; i < MASTER_NUM; i++) master_c = master_c | idx_terms[i];
   end

   assign acc_c       = (state_q == OWN) & ~arb_if.hwait;
   assign owner_req_c = |(grant_q & arb_if.hreq);

   // End of ownership: last beat of the burst accepted, or an INCR owner
   // that has stopped requesting (with or without a beat this cycle).
   assign rel_c = (state_q == OWN) &
                  ((acc_c & (beat_cnt_q == beat_limit_q - CNT_W'(1))) |
                   ((burst_q == 3'd1) & ~owner_req_c));

   // Winner selection from the current requests.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      best_prio = '0;
      case (arb_if.arb_mode)
         2'd1: begin
            // Round-robin: indices above the last winner first, then wrap.
            for (int i = 0; i < MASTER_NUM; i++) begin
               if (!win_found && arb_if.hreq[i] && (i > int'(rr_ptr_q))) begin
                  win_found = 1'b1;
                  win_idx   = IDX_W'(i);
               end
            end
            for (int i = 0; i < MASTER_NUM; i++) begin
               if (!win_found && arb_if.hreq[i] && (i <= int'(rr_ptr_q))) begin
                  win_found = 1'b1;
                  win_idx   = IDX_W'(i);
               end
            end
         end
         2'd2: begin
            // Strictly-greater update keeps the lowest index on ties.
            for (int i = 0; i < MASTER_NUM; i++) begin
               if (arb_if.hreq[i] && (!win_found || (arb_if.hprior[i] > best_prio))) begin
                  win_found = 1'b1;
                  win_idx   = IDX_W'(i);
                  best_prio = arb_if.hprior[i];
               end
            end
         end
         default: begin
            for (int i = 0; i < MASTER_NUM; i++) begin
               if (!win_found && arb_if.hreq[i]) begin
                  win_found = 1'b1;
                  win_idx   = IDX_W'(i);
               end
            end
         end
      endcase
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_ptr_d     = rr_ptr_q;
      beat_cnt_d   = beat_cnt_q;
      beat_limit_d = beat_limit_q;
      burst_d      = burst_q;
      if ((state_q == IDLE) || rel_c) begin
         if (win_found) begin
            state_d      = OWN;
            grant_d      = MASTER_NUM'(1) << win_idx;
            rr_ptr_d     = win_idx;
            burst_d      = arb_if.hburst[win_idx];
            beat_limit_d = limit_of(arb_if.hburst[win_idx]);
            beat_cnt_d   = '0;
         end else begin
            state_d    = IDLE;
            grant_d    = '0;
            beat_cnt_d = '0;
         end
      end else if (acc_c && (beat_cnt_q != '1)) begin
         beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         rr_ptr_q     <= IDX_W'(MASTER_NUM - 1);
         beat_cnt_q   <= '0;
         beat_limit_q <= CNT_W'(1);
         burst_q      <= 3'd0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         rr_ptr_q     <= rr_ptr_d;
         beat_cnt_q   <= beat_cnt_d;
         beat_limit_q <= beat_limit_d;
         burst_q      <= burst_d;
      end
   end

   assign arb_if.hgrant  = grant_q;
   assign arb_if.hsel    = |grant_q;
   assign arb_if.hmaster = master_c;
   assign arb_if.hlast   = rel_c & acc_c;
endmodule

// File: tb/tb_ahb_slave_arbiter_gen.sv
// ----------------------------------------------------------------------------
// tb_ahb_slave_arbiter_gen
// Directed bench for ahb_slave_arbiter_gen (4 masters, HOLD_MAX=4). A
// transaction-level ownership model predicts every output on every cycle;
// directed scenarios add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_ahb_slave_arbiter_gen;
   localparam int N    = 4;
   localparam int PB   = 2;
   localparam int HOLD = 4;

   logic hclk;
   logic hreset;

   logic [N-1:0]         hreq;
   logic [N-1:0][2:0]    hburst;
   logic [N-1:0][PB-1:0] hprior;
   logic [1:0]           arb_mode;
   logic                 hwait;

   int errors = 0;
   int checks = 0;

   ahb_slave_arbiter_gen_if #(.MASTER_NUM(N), .PRIOR_BIT(PB)) bus ();

   assign bus.hreq     = hreq;
   assign bus.hburst   = hburst;
   assign bus.hprior   = hprior;
   assign bus.arb_mode = arb_mode;
   assign bus.hwait    = hwait;

   ahb_slave_arbiter_gen #(.MASTER_NUM(N), .PRIOR_BIT(PB), .HOLD_MAX(HOLD)) dut (
      .hclk   (hclk),
      .hreset (hreset),
      .arb_if (bus)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- ownership model ----------------
   int m_owner;   // -1 when nobody owns the slave
   int m_beats;   // beats accepted so far in this ownership
   int m_limit;   // beats this ownership may take
   bit m_incr;
   int m_rr;      // last master granted

   function automatic int lim_of(input logic [2:0] b);
      case (b)
         3'd0:       return 1;
         3'd1:       return HOLD;
         3'd2, 3'd3: return 4;
         3'd4, 3'd5: return 8;
         default:    return 16;
      endcase
   endfunction

   function automatic int pick();
      int w = -1;
      if (arb_mode == 2'd1) begin
         for (int k = 1; k <= N; k++) begin
            int c = (m_rr + k) % N;
            if (w < 0 && hreq[c]) w = c;
         end
      end else if (arb_mode == 2'd2) begin
         for (int i = 0; i < N; i++)
            if (hreq[i] && (w < 0 || hprior[i] > hprior[w])) w = i;
      end else begin
         for (int i = 0; i < N; i++)
            if (w < 0 && hreq[i]) w = i;
      end
      return w;
   endfunction

   initial begin
      m_owner = -1; m_beats = 0; m_limit = 1; m_incr = 0; m_rr = N - 1;
      forever begin
         @(posedge hclk or posedge hreset);
         if (hreset) begin
            m_owner = -1; m_beats = 0; m_rr = N - 1;
         end else begin
            bit acc;
            bit fin;
            int w;
            acc = (m_owner >= 0) && !hwait;
            if (m_owner < 0) fin = 1'b1;
            else fin = (acc && (m_beats + 1 == m_limit)) || (m_incr && !hreq[m_owner]);
            if (!fin && acc) m_beats++;
            if (fin) begin
               w = pick();
               if (w < 0) m_owner = -1;
               else begin
                  m_owner = w;
                  m_beats = 0;
                  m_limit = lim_of(hburst[w]);
                  m_incr  = (hburst[w] == 3'd1);
                  m_rr    = w;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         logic [N-1:0] eg;
         logic [1:0]   em;
         logic         el;
         @(negedge hclk);
         eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
         em = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
         el = (m_owner >= 0) && !hwait &&
              ((m_beats + 1 == m_limit) || (m_incr && !hreq[m_owner]));
         chk("model_hgrant", 32'(bus.hgrant), 32'(eg));
         chk("model_hsel", 32'(bus.hsel), 32'(m_owner >= 0));
         chk("model_hmaster", 32'(bus.hmaster), 32'(em));
         chk("model_hlast", 32'(bus.hlast), 32'(el));
      end
   end

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int own;
      int nlast;
      int last_at;
      logic [N-1:0] g [0:4];
      logic         l [0:4];

      hreset = 1'b1; hreq = '0; hburst = '0; hprior = '0; arb_mode = 2'd0; hwait = 1'b0;
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      chk("reset_hgrant", 32'(bus.hgrant), 32'h0);
      chk("reset_hmaster", 32'(bus.hmaster), 32'h0);
      $display("reset: hgrant=%b hsel=%b hmaster=%0d", bus.hgrant, bus.hsel, bus.hmaster);
      step(); hreset = 1'b0;
      step();

      // Fixed priority, masters 1 and 3 requesting SINGLE.
      hreq = 4'b1010;
      step(); hreq = 4'b1000;
      @(negedge hclk);
      chk("fixed_first", 32'(bus.hgrant), 32'b0010);
      chk("fixed_hlast", 32'(bus.hlast), 32'h1);
      $display("fixed: hgrant=%b hlast=%b", bus.hgrant, bus.hlast);
      step(); hreq = 4'b0000;
      @(negedge hclk);
      chk("fixed_second", 32'(bus.hgrant), 32'b1000);
      $display("fixed: hgrant=%b hlast=%b", bus.hgrant, bus.hlast);
      step(); step();

      // Round-robin, all four requesting SINGLE.
      arb_mode = 2'd1; hreq = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         step();
         if (k == 4) hreq = 4'b0000;
         @(negedge hclk);
         chk("rr_seq", 32'(bus.hgrant), 32'(4'b0001 << (k % 4)));
         $display("rr: step %0d hgrant=%b", k, bus.hgrant);
      end
      step(); step();

      // Dynamic priority with INCR4 bursts, tie between masters 1 and 3.
      arb_mode = 2'd2; hprior = {2'd3, 2'd1, 2'd3, 2'd0};
      hburst = {3'd3, 3'd3, 3'd3, 3'd3}; hreq = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         step();
         if (k == 1) hprior[2] = 2'd3;
         if (k == 3) hreq = 4'b0000;
         @(negedge hclk);
         chk("dyn_hold", 32'(bus.hgrant), 32'b0010);
         chk("dyn_hlast", 32'(bus.hlast), 32'(k == 3));
         $display("dyn: beat %0d hgrant=%b hlast=%b", k + 1, bus.hgrant, bus.hlast);
      end
      step();
      @(negedge hclk);
      chk("dyn_idle", 32'(bus.hgrant), 32'h0);

      // Master 0 INCR8 with stalls and an early request drop.
      arb_mode = 2'd0; hprior = '0; hburst = '0; hburst[0] = 3'd5;
      step(); hreq = 4'b0001;
      own = 0; nlast = 0; last_at = -1;
      for (int c = 0; c < 12; c++) begin
         step();
         hwait = (c == 2 || c == 5);
         if (c == 2) hreq = 4'b0000;
         @(negedge hclk);
         if (bus.hgrant == 4'b0001) own++;
         if (bus.hlast) begin nlast++; last_at = c; end
      end
      hwait = 1'b0;
      chk("incr8_cycles", 32'(own), 32'd10);
      chk("incr8_nlast", 32'(nlast), 32'd1);
      chk("incr8_last_at", 32'(last_at), 32'd9);
      $display("incr8: owned %0d cycles, hlast pulses %0d at cycle %0d", own, nlast, last_at);

      // Master 2 INCR held: forced release after HOLD beats.
      hburst = '0; hburst[2] = 3'd1;
      step(); hreq = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         step();
         if (c == 4) hreq = 4'b0000;
         @(negedge hclk);
         g[c] = bus.hgrant; l[c] = bus.hlast;
      end
      for (int c = 0; c < 5; c++) begin
         chk("hold_grant", 32'(g[c]), 32'b0100);
         if (c < 4) chk("hold_hlast", 32'(l[c]), 32'(c == 3));
      end
      $display("incr hold: hlast pattern %b%b%b%b", l[0], l[1], l[2], l[3]);
      step(); step();

      // Master 2 INCR drops its request while stalled, master 3 pending.
      hburst[3] = 3'd0;
      step(); hreq = 4'b1100;
      for (int c = 0; c < 4; c++) begin
         step();
         if (c == 2) begin hreq = 4'b1000; hwait = 1'b1; end
         if (c == 3) begin hreq = 4'b0000; hwait = 1'b0; end
         @(negedge hclk);
         g[c] = bus.hgrant; l[c] = bus.hlast;
      end
      chk("drop_owner", 32'(g[2]), 32'b0100);
      chk("drop_hlast", 32'(l[2]), 32'h0);
      chk("drop_switch", 32'(g[3]), 32'b1000);
      $display("incr drop: hgrant %b -> %b, hlast=%b", g[2], g[3], l[2]);
      step(); step();

      // Reset in the middle of a WRAP16 burst at beat 7.
      hburst = '0; hburst[1] = 3'd6; hburst[2] = 3'd6;
      step(); hreq = 4'b0010;
      for (int c = 0; c < 7; c++) step();
      hreset = 1'b1;
      #1;
      chk("async_rst_hgrant", 32'(bus.hgrant), 32'h0);
      chk("async_rst_hsel", 32'(bus.hsel), 32'h0);
      $display("async reset: hgrant=%b hsel=%b", bus.hgrant, bus.hsel);
      step(); hreset = 1'b0; hreq = 4'b0100;
      own = 0; nlast = 0; last_at = -1;
      for (int c = 0; c < 18; c++) begin
         step();
         if (c == 1) hreq = 4'b0000;
         @(negedge hclk);
         if (c == 0) chk("post_rst_grant", 32'(bus.hgrant), 32'b0100);
         if (bus.hgrant == 4'b0100) own++;
         if (bus.hlast) begin nlast++; last_at = c; end
      end
      chk("post_rst_cycles", 32'(own), 32'd16);
      chk("post_rst_last_at", 32'(last_at), 32'd15);
      $display("post reset wrap16: owned %0d cycles, hlast at cycle %0d", own, last_at);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
